// File: rtl/hook_pkg.sv
`default_nettype none
// ============================================================================
// Module : hook_pkg
// Brief  : Shared widths, FSM states and motion modes for the hook sequencer.
// Rev    : 1.0
// ============================================================================
package hook_pkg;

    localparam int DEG_W   = 9;
    localparam int LEN_W   = 10;
    localparam int ARITH_W = 11;

    typedef enum logic [2:0] {
        S_WAIT       = 3'd0,
        S_ERASE_GO   = 3'd1,
        S_ERASE_WAIT = 3'd2,
        S_UPDATE     = 3'd3,
        S_DRAW_GO    = 3'd4,
        S_DRAW_WAIT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        M_SWING   = 2'd0,
        M_EXTEND  = 2'd1,
        M_RETRACT = 2'd2
    } mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/hook_motion.sv
`default_nettype none
// ============================================================================
// Module : hook_motion
// Brief  : Combinational next-frame angle/length/mode for the hook.
// Rev    : 1.0
// ============================================================================
module hook_motion
    import hook_pkg::*;
#(
    parameter int unsigned DEG_MIN   = 10,
    parameter int unsigned DEG_MAX   = 170,
    parameter int unsigned DEG_STEP  = 2,
    parameter int unsigned LEN_MIN   = 20,
    parameter int unsigned LEN_MAX   = 300,
    parameter int unsigned EXT_STEP  = 4,
    parameter int unsigned RET_STEP  = 2,
    parameter int unsigned RET_HEAVY = 1
) (
    input  logic [DEG_W-1:0] i_degree,
    input  logic [LEN_W-1:0] i_length,
    input  mode_t            i_mode,
    input  logic             i_dir,
    input  logic             i_grabbed,
    input  logic             i_hit,
    input  logic             i_heavy,
    input  logic             i_fire_pend,
    output logic [DEG_W-1:0] o_degree,
    output logic [LEN_W-1:0] o_length,
    output mode_t            o_mode,
    output logic             o_dir,
    output logic             o_grabbed,
    output logic             o_fire_clr,
    output logic             o_reel_done
);

    localparam logic [ARITH_W-1:0] c_DEG_MAX    = ARITH_W'(DEG_MAX);
    localparam logic [ARITH_W-1:0] c_DEG_DN_LIM = ARITH_W'(DEG_MIN + DEG_STEP);
    localparam logic [ARITH_W-1:0] c_LEN_MAX    = ARITH_W'(LEN_MAX);
    localparam logic [ARITH_W-1:0] c_LEN_MIN    = ARITH_W'(LEN_MIN);

    logic [ARITH_W-1:0] w_deg;
    logic [ARITH_W-1:0] w_len;
    logic [ARITH_W-1:0] w_deg_up;
    logic [ARITH_W-1:0] w_deg_dn;
    logic [ARITH_W-1:0] w_len_up;
    logic [ARITH_W-1:0] w_ret_step;
    logic [ARITH_W-1:0] w_len_dn;

    assign w_deg      = ARITH_W'(i_degree);
    assign w_len      = ARITH_W'(i_length);
    assign w_deg_up   = w_deg + ARITH_W'(DEG_STEP);
    assign w_deg_dn   = w_deg - ARITH_W'(DEG_STEP);
    assign w_len_up   = w_len + ARITH_W'(EXT_STEP);
    assign w_ret_step = (i_heavy && i_grabbed) ? ARITH_W'(RET_HEAVY) : ARITH_W'(RET_STEP);
    assign w_len_dn   = w_len - w_ret_step;

    always_comb begin
        o_degree    = i_degree;
        o_length    = i_length;
        o_mode      = i_mode;
        o_dir       = i_dir;
        o_grabbed   = i_grabbed;
        o_fire_clr  = 1'b0;
        o_reel_done = 1'b0;
        case (i_mode)
            M_SWING: begin
                // A pending launch takes the whole frame; the angle freezes here.
                if (i_fire_pend) begin
                    o_mode     = M_EXTEND;
                    o_fire_clr = 1'b1;
                    o_grabbed  = 1'b0;
                end else if (i_dir == DIR_UP) begin
                    if (w_deg_up >= c_DEG_MAX) begin
                        o_degree = DEG_W'(DEG_MAX);
                        o_dir    = DIR_DOWN;
                    end else begin
                        o_degree = w_deg_up[DEG_W-1:0];
                    end
                end else begin
                    // Compare before subtracting so a small angle cannot wrap.
                    if (w_deg <= c_DEG_DN_LIM) begin
                        o_degree = DEG_W'(DEG_MIN);
                        o_dir    = DIR_UP;
                    end else begin
                        o_degree = w_deg_dn[DEG_W-1:0];
                    end
                end
            end
            M_EXTEND: begin
                if (i_hit) begin
                    o_grabbed = 1'b1;
                    o_mode    = M_RETRACT;
                end else if (w_len_up >= c_LEN_MAX) begin
                    o_length = LEN_W'(LEN_MAX);
                    o_mode   = M_RETRACT;
                end else begin
                    o_length = w_len_up[LEN_W-1:0];
                end
            end
            M_RETRACT: begin
                if (w_len <= c_LEN_MIN + w_ret_step) begin
                    o_length    = LEN_W'(LEN_MIN);
                    o_mode      = M_SWING;
                    o_reel_done = 1'b1;
                end else begin
                    o_length = w_len_dn[LEN_W-1:0];
                end
            end
            default: o_mode = M_SWING;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hook_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hook_ctrl
// Brief  : Per-frame erase/update/redraw sequencer driving the hook drawer.
// Rev    : 1.0
// ============================================================================
module hook_ctrl
    import hook_pkg::*;
#(
    parameter int unsigned DEG_MIN   = 10,
    parameter int unsigned DEG_MAX   = 170,
    parameter int unsigned DEG_STEP  = 2,
    parameter int unsigned LEN_MIN   = 20,
    parameter int unsigned LEN_MAX   = 300,
    parameter int unsigned EXT_STEP  = 4,
    parameter int unsigned RET_STEP  = 2,
    parameter int unsigned RET_HEAVY = 1,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_frame_tick,
    input  logic             i_fire,
    input  logic             i_hit,
    input  logic             i_heavy,
    input  logic             i_draw_done,
    output logic [DEG_W-1:0] o_degree,
    output logic [LEN_W-1:0] o_length,
    output logic             o_draw_enable,
    output logic             o_erase,
    output logic             o_busy,
    output logic             o_reel_done,
    output logic             o_grabbed,
    output logic             o_error
);

    localparam int             CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

    state_t           r_state;
    logic [DEG_W-1:0] r_degree;
    logic [LEN_W-1:0] r_length;
    mode_t            r_mode;
    logic             r_dir;
    logic             r_grabbed;
    logic             r_fire_pend;
    logic             r_drawn_valid;
    logic             r_draw_enable;
    logic             r_erase;
    logic             r_busy;
    logic             r_reel_done;
    logic             r_error;
    logic [CNT_W-1:0] r_cnt;

    logic [DEG_W-1:0] w_degree;
    logic [LEN_W-1:0] w_length;
    mode_t            w_mode;
    logic             w_dir;
    logic             w_grabbed;
    logic             w_fire_clr;
    logic             w_reel_done;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout;

    hook_motion #(
        .DEG_MIN  (DEG_MIN),
        .DEG_MAX  (DEG_MAX),
        .DEG_STEP (DEG_STEP),
        .LEN_MIN  (LEN_MIN),
        .LEN_MAX  (LEN_MAX),
        .EXT_STEP (EXT_STEP),
        .RET_STEP (RET_STEP),
        .RET_HEAVY(RET_HEAVY)
    ) u_motion (
        .i_degree   (r_degree),
        .i_length   (r_length),
        .i_mode     (r_mode),
        .i_dir      (r_dir),
        .i_grabbed  (r_grabbed),
        .i_hit      (i_hit),
        .i_heavy    (i_heavy),
        .i_fire_pend(r_fire_pend),
        .o_degree   (w_degree),
        .o_length   (w_length),
        .o_mode     (w_mode),
        .o_dir      (w_dir),
        .o_grabbed  (w_grabbed),
        .o_fire_clr (w_fire_clr),
        .o_reel_done(w_reel_done)
    );

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == c_TIMEOUT);

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state       <= S_WAIT;
            r_degree      <= DEG_W'((DEG_MIN + DEG_MAX) / 2);
            r_length      <= LEN_W'(LEN_MIN);
            r_mode        <= M_SWING;
            r_dir         <= DIR_UP;
            r_grabbed     <= 1'b0;
            r_fire_pend   <= 1'b0;
            r_drawn_valid <= 1'b0;
            r_draw_enable <= 1'b0;
            r_erase       <= 1'b0;
            r_busy        <= 1'b0;
            r_reel_done   <= 1'b0;
            r_error       <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_draw_enable <= 1'b0;
            r_reel_done   <= 1'b0;
            r_error       <= 1'b0;
            if (r_state != S_WAIT) begin
                r_cnt <= w_cnt_inc;
            end
            if (i_fire && (r_mode == M_SWING)) begin
                r_fire_pend <= 1'b1;
            end
            // Ticks arriving mid-frame are dropped, not queued.
            if (i_frame_tick && r_busy) begin
                r_error <= 1'b1;
            end
            case (r_state)
                S_WAIT: begin
                    if (i_frame_tick) begin
                        r_busy <= 1'b1;
                        if (r_drawn_valid) begin
                            r_state       <= S_ERASE_GO;
                            r_draw_enable <= 1'b1;
                            r_erase       <= 1'b1;
                            r_cnt         <= '0;
                        end else begin
                            r_state <= S_UPDATE;
                        end
                    end
                end
                S_ERASE_GO: r_state <= S_ERASE_WAIT;
                S_ERASE_WAIT: begin
                    if (i_draw_done) begin
                        r_state <= S_UPDATE;
                        r_erase <= 1'b0;
                    end else if (w_timeout) begin
                        r_state       <= S_WAIT;
                        r_busy        <= 1'b0;
                        r_erase       <= 1'b0;
                        r_error       <= 1'b1;
                        r_drawn_valid <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    r_degree      <= w_degree;
                    r_length      <= w_length;
                    r_mode        <= w_mode;
                    r_dir         <= w_dir;
                    r_grabbed     <= w_grabbed;
                    r_reel_done   <= w_reel_done;
                    if (w_fire_clr) begin
                        r_fire_pend <= 1'b0;
                    end
                    r_state       <= S_DRAW_GO;
                    r_draw_enable <= 1'b1;
                    r_cnt         <= '0;
                end
                S_DRAW_GO: r_state <= S_DRAW_WAIT;
                S_DRAW_WAIT: begin
                    if (i_draw_done) begin
                        r_state       <= S_WAIT;
                        r_busy        <= 1'b0;
                        r_drawn_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state       <= S_WAIT;
                        r_busy        <= 1'b0;
                        r_error       <= 1'b1;
                        r_drawn_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_busy  <= 1'b0;
                    r_erase <= 1'b0;
                end
            endcase
        end
    end

    assign o_degree      = r_degree;
    assign o_length      = r_length;
    assign o_draw_enable = r_draw_enable;
    assign o_erase       = r_erase;
    assign o_busy        = r_busy;
    assign o_reel_done   = r_reel_done;
    assign o_grabbed     = r_grabbed;
    assign o_error       = r_error;

endmodule
`default_nettype wire
